// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit arbiter: opcodes, response-slot states, stat width.
package lu_pkg;

  localparam logic [1:0] LU_OR  = 2'b00;
  localparam logic [1:0] LU_AND = 2'b01;
  localparam logic [1:0] LU_XOR = 2'b10;
  localparam logic [1:0] LU_NOR = 2'b11;

  typedef enum logic {
    LU_EMPTY = 1'b0,
    LU_FULL  = 1'b1
  } lu_state_e;

  localparam int unsigned LU_STAT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any_gnt
);

  always_comb begin
    logic [ID_W-1:0] idx;
    int unsigned     pos;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = '0;
    pos     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = (32'(ptr) + i) % NUM_REQ;
      idx = ID_W'(pos);
      if (req[idx] && !any_gnt) begin
        gnt_idx = idx;
        any_gnt = 1'b1;
      end
    end
    if (any_gnt) begin
      gnt = NUM_REQ'(1) << gnt_idx;
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one bitwise logic unit among NUM_REQ requesters with a registered response slot.
// Optional per-requester grant counters are built when LU_ARB_STATS_EN is defined.
module logic_unit_arbiter
  import lu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data
`ifdef LU_ARB_STATS_EN
  ,
  input  logic [ID_W-1:0]          stat_sel,
  output logic [LU_STAT_W-1:0]     stat_count
`endif
);

  lu_state_e        state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_gnt;
  logic               can_accept;
  logic               accept;
  logic [1:0]         op_g;
  logic [WIDTH-1:0]   a_g, b_g, result;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Reset gates acceptance so no handshake can complete while rst is held.
  assign can_accept = !rst && ((state_q == LU_EMPTY) || rsp_ready);
  assign accept     = any_gnt && can_accept;
  assign req_ready  = accept ? gnt : '0;

  assign op_g = req_op[2*32'(gnt_idx) +: 2];
  assign a_g  = req_a[WIDTH*32'(gnt_idx) +: WIDTH];
  assign b_g  = req_b[WIDTH*32'(gnt_idx) +: WIDTH];

  always_comb begin
    result = '0;
    unique case (op_g)
      LU_OR:   result = a_g | b_g;
      LU_AND:  result = a_g & b_g;
      LU_XOR:  result = a_g ^ b_g;
      LU_NOR:  result = ~(a_g | b_g);
      default: result = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    if (accept) begin
      state_d    = LU_FULL;
      rsp_id_d   = gnt_idx;
      rsp_data_d = result;
      rr_ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (state_q == LU_FULL && rsp_ready) begin
      state_d = LU_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LU_EMPTY;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rsp_valid = (state_q == LU_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef LU_ARB_STATS_EN
  logic [LU_STAT_W-1:0] cnt_q [NUM_REQ];
  logic [LU_STAT_W-1:0] cnt_d [NUM_REQ];

  // Counters saturate rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q[gnt_idx] != '1)) begin
      cnt_d[gnt_idx] = cnt_q[gnt_idx] + LU_STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    stat_count = '0;
    if (32'(stat_sel) < NUM_REQ) begin
      stat_count = cnt_q[stat_sel];
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_logic_unit_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [2*N-1:0] req_op;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
`ifdef LU_ARB_STATS_EN
  logic [1:0]    stat_sel;
  logic [15:0]   stat_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (32),
    .ID_W    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef LU_ARB_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
`endif
  );

  function automatic logic [31:0] lu_f(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    case (op)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[2*i +: 2] = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_op = '0;
    req_a = '0;
    req_b = '0;
`ifdef LU_ARB_STATS_EN
    stat_sel = 2'd0;
`endif
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_data !== 32'd0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    @(negedge clk);
    req_valid = 4'b0001;
    set_req(0, 2'b00, 32'hF0F0_0000, 32'h0000_0F0F);
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_data !== 32'hF0F0_0F0F) begin failures++; $display("FAIL single_data got=%h exp=f0f00f0f", rsp_data); end
  endtask

  task automatic test_all_ops();
    logic [31:0] exp [3];
    exp[0] = 32'h0F0F_0000;
    exp[1] = 32'hF0F0_0F0F;
    exp[2] = 32'h0000_F0F0;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      set_req(2, 2'(k + 1), 32'hFFFF_0000, 32'h0F0F_0F0F);
      #1;
      checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL ops_ready[%0d] got=%b exp=0100", k, req_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== exp[k]) begin
        failures++;
        $display("FAIL ops_rsp[%0d] got=%b/%0d/%h exp=1/2/%h", k, rsp_valid, rsp_id, rsp_data, exp[k]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    int order [12];
    order = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0};
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 2'b00, 32'(i), 32'h0);
    req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      if (k == 6) req_valid = 4'b1101;
      #1;
      checks++; if (req_ready !== 4'(1 << order[k])) begin
        failures++;
        $display("FAIL rr_grant[%0d] got=%b exp=%b", k, req_ready, 4'(1 << order[k]));
      end
      tick();
      checks++; if (rsp_id !== 2'(order[k])) begin failures++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, rsp_id, order[k]); end
    end
    req_valid = '0;
  endtask

  task automatic test_back_pressure();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'(i), 32'h1111_1111 * (i + 1), 32'hF0F0_F0F0);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_first_ready got=%b exp=0001", req_ready); end
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== lu_f(2'd0, 32'h1111_1111, 32'hF0F0_F0F0)) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=%b/%0d/%h exp=1/0/%h", k, rsp_valid, rsp_id, rsp_data,
                 lu_f(2'd0, 32'h1111_1111, 32'hF0F0_F0F0));
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_ready got=%b exp=0010", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== lu_f(2'd1, 32'h2222_2222, 32'hF0F0_F0F0)) begin
      failures++;
      $display("FAIL bp_release_rsp got=%b/%0d/%h exp=1/1/%h", rsp_valid, rsp_id, rsp_data,
               lu_f(2'd1, 32'h2222_2222, 32'hF0F0_F0F0));
    end
  endtask

  task automatic test_reset_mid_op();
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    tick();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", rsp_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", rsp_valid); end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_after_ready got=%b exp=0001", req_ready); end
    tick();
    checks++; if (rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_after_rsp got=%b/%0d exp=1/0", rsp_valid, rsp_id);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    bit          pending [N];
    logic [1:0]  r_op [N];
    logic [31:0] r_a [N];
    logic [31:0] r_b [N];
    int          m_ptr;
    bit          m_full;
    int          m_id;
    logic [31:0] m_data;
    int          g;
    bit          can;
    logic [3:0]  exp_ready;
    do_reset();
    m_ptr = 0;
    m_full = 0;
    m_id = 0;
    m_data = '0;
    for (int i = 0; i < N; i++) pending[i] = 0;
    tick();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 2) == 0) begin
          pending[i] = 1;
          r_op[i] = 2'($urandom_range(0, 3));
          r_a[i] = $urandom;
          r_b[i] = $urandom;
        end
        req_valid[i] = pending[i];
        if (pending[i]) set_req(i, r_op[i], r_a[i], r_b[i]);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      can = !m_full || rsp_ready;
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && pending[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      exp_ready = (g >= 0 && can) ? 4'(1 << g) : 4'b0000;
      checks++; if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL rand_ready[%0d] got=%b exp=%b", cyc, req_ready, exp_ready);
      end
      tick();
      if (g >= 0 && can) begin
        m_full = 1;
        m_id = g;
        m_data = lu_f(r_op[g], r_a[g], r_b[g]);
        m_ptr = (g + 1) % N;
        pending[g] = 0;
      end else if (m_full && rsp_ready) begin
        m_full = 0;
      end
      checks++; if (rsp_valid !== m_full || rsp_id !== 2'(m_id) || rsp_data !== m_data) begin
        failures++;
        $display("FAIL rand_rsp[%0d] got=%b/%0d/%h exp=%b/%0d/%h", cyc, rsp_valid, rsp_id, rsp_data,
                 m_full, m_id, m_data);
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
  endtask

`ifdef LU_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    stat_sel = 2'd3;
    #1;
    checks++; if (stat_count !== 16'd0) begin failures++; $display("FAIL stat_idle got=%0d exp=0", stat_count); end
    rsp_ready = 1'b1;
    set_req(1, 2'b00, 32'h1, 32'h2);
    req_valid = 4'b0010;
    repeat (3) tick();
    req_valid = '0;
    stat_sel = 2'd1;
    #1;
    checks++; if (stat_count !== 16'd3) begin failures++; $display("FAIL stat_three got=%0d exp=3", stat_count); end
    req_valid = 4'b0010;
    repeat (65532) tick();
    req_valid = '0;
    #1;
    checks++; if (stat_count !== 16'hFFFF) begin failures++; $display("FAIL stat_full got=%h exp=ffff", stat_count); end
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    #1;
    checks++; if (stat_count !== 16'hFFFF) begin failures++; $display("FAIL stat_saturate got=%h exp=ffff", stat_count); end
    stat_sel = 2'd3;
    #1;
    checks++; if (stat_count !== 16'd0) begin failures++; $display("FAIL stat_other got=%0d exp=0", stat_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_op();
    test_all_ops();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_op();
    test_random();
`ifdef LU_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 32-bit bitwise logic unit (OR/AND/XOR/NOR) among NUM_REQ requesters in the MIPS-16 datapath, e.g. the ALU issue slot, the branch-mask unit and the debug port.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the result and returns it with the requester ID on a single response channel that has back-pressure.

Parameters:
- NUM_REQ, 4: number of requesters; legal values 2–8.
- WIDTH, 32: operand and result width.
- ID_W, 2: requester ID width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept strobe; one-hot or zero.
- req_op  in  2*NUM_REQ  per-requester opcode; slice i is [2i+1:2i]. 00=OR, 01=AND, 10=XOR, 11=NOR.
- req_a  in  WIDTH*NUM_REQ  per-requester operand A.
- req_b  in  WIDTH*NUM_REQ  per-requester operand B.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester the result belongs to.
- rsp_data  out  WIDTH  registered logic result.
- stat_sel  in  ID_W  statistics select; present only with LU_ARB_STATS_EN.
- stat_count  out  16  grant count for stat_sel; present only with LU_ARB_STATS_EN.

Behaviour:
- Reset (async, rst=1):
  - state=EMPTY, rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0.
  - Statistics counters=0.
  - Reset asserted mid-transaction discards any held response. No partial handshake survives reset.
- States:
  - EMPTY: no response held.
  - FULL: response held, rsp_valid=1.
- can_accept = (state==EMPTY) | (state==FULL & rsp_ready).
- Arbitration (combinational, each cycle):
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first asserted requester g is granted.
  - req_ready[g] = can_accept; all other req_ready bits are 0.
  - With no req_valid, req_ready=0.
- Accept (req_valid[g] & req_ready[g]) at edge t:
  - rsp_data <= f(op_g, a_g, b_g); rsp_id <= g; state <= FULL.
  - rsp_valid is high from cycle t+1 (one-cycle latency).
  - rr_ptr <= (g+1) mod NUM_REQ. For NUM_REQ not a power of 2, the wrap from NUM_REQ-1 goes to 0.
- Response drain:
  - FULL & rsp_ready & no accept: state <= EMPTY. rsp_data and rsp_id hold their last values.
  - FULL & rsp_ready & accept in the same cycle: stay FULL and load the new result. This gives full throughput of one op per cycle.
  - FULL & !rsp_ready: hold rsp_valid, rsp_id and rsp_data stable; req_ready=0.
- rr_ptr changes only on accept. Idle cycles never rotate priority.
- Fairness: a continuously asserted requester is granted within NUM_REQ accepts.
- A requester must hold valid, op and operands stable until req_ready. The block does not check this.
- Operations are bitwise only, with no carry, so the result width equals WIDTH.

Optional Feature:
- LU_ARB_STATS_EN defined:
  - Adds stat_sel and stat_count ports.
  - Adds one 16-bit counter per requester, incremented on each accept by that requester.
  - Counters saturate at 16'hFFFF and do not wrap.
  - Readout is combinational by stat_sel. A stat_sel >= NUM_REQ returns 0.
- LU_ARB_STATS_EN undefined:
  - Ports and counters are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package lu_pkg holds:
  - opcode localparams LU_OR=2'b00, LU_AND=2'b01, LU_XOR=2'b10, LU_NOR=2'b11;
  - state encodings LU_EMPTY/LU_FULL;
  - the stat counter width 16.
- One sub-module, rr_arbiter:
  - inputs: req vector and rr_ptr;
  - outputs: one-hot grant, grant index and any_grant.
- The logic function is a single case on opcode inside the top module; the existing ORX is not instantiated.

Test Plan:
- Reset, then single op: after reset, req_valid=0001, op=OR, a=32'hF0F0_0000, b=32'h0000_0F0F. Expect req_ready[0]=1, and next cycle rsp_valid=1, rsp_id=0, rsp_data=32'hF0F0_0F0F.
- All ops: requester 2 issues AND, XOR and NOR back-to-back with a=32'hFFFF_0000, b=32'h0F0F_0F0F and rsp_ready=1. Expect 32'h0F0F_0000, 32'hF0F0_0F0F, 32'h0000_F0F0 on consecutive cycles with rsp_id=2.
- Round-robin: all four req_valid held high with rsp_ready=1. Expect grant order 0,1,2,3,0,1 on consecutive cycles. Then drop req 1 and expect the sequence to skip 1.
- Back-pressure: rsp_ready=0 while FULL with req_valid=1111. Expect req_ready=0000 and rsp_data/rsp_id stable for 5 cycles. Raising rsp_ready gives a drain and a new accept in the same cycle.
- Reset mid-op: assert rst while FULL with rsp_valid=1. Expect rsp_valid=0 immediately (async), rr_ptr=0, and next grant to requester 0.
- LU_ARB_STATS_EN: issue 3 grants to requester 1, then set stat_sel=1 and expect stat_count=3. Force the counter to 16'hFFFF, issue one more grant, and expect it to stay 16'hFFFF. stat_sel=3 after no grants gives 0.
